// File: rtl/sd_pkg.sv
// Shared SD command definitions: indices, response types, error codes
// and fixed arguments used by the init sequencer and the command engine.
package sd_pkg;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD2   = 6'd2;
    localparam logic [5:0] CMD3   = 6'd3;
    localparam logic [5:0] CMD7   = 6'd7;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_R1   = 2'd1;
    localparam logic [1:0] RESP_R3   = 2'd2;
    localparam logic [1:0] RESP_R2   = 2'd3;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_CRC     = 3'd2;
    localparam logic [2:0] ERR_ECHO    = 3'd3;
    localparam logic [2:0] ERR_RETRY   = 3'd4;
    localparam logic [2:0] ERR_RCA     = 3'd5;

    localparam logic [31:0] CMD8_ARG       = 32'h0000_01AA;
    localparam logic [11:0] CMD8_ECHO      = 12'h1AA;
    localparam logic [31:0] ACMD41_ARG_HCS = 32'h40FF_8000;
    localparam logic [31:0] ACMD41_ARG_SD  = 32'h00FF_8000;

    typedef struct packed {
        logic [1:0]  rtype;
        logic [5:0]  index;
        logic [31:0] arg;
    } sd_cmd_t;

    function automatic sd_cmd_t mk_cmd(logic [5:0] i, logic [31:0] a,
                                       logic [1:0] t);
        sd_cmd_t c;
        c.rtype = t;
        c.index = i;
        c.arg   = a;
        return c;
    endfunction

endpackage

// File: rtl/sd_init_sequencer.sv
// Drives the SD command engine through card initialization
// (CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3, CMD7).
module sd_init_sequencer
    import sd_pkg::*;
#(
    parameter int CLK_FRE        = 27,
    parameter int POWERUP_US     = 1000,
    parameter int ACMD41_RETRIES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        cmd_start,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic [1:0]  cmd_resp_type,
    input  logic        cmd_done,
    input  logic        cmd_timeout,
    input  logic        cmd_crc_err,
    input  logic [31:0] resp_arg,
    output logic        fast_clk_sel,
    output logic        busy,
    output logic        init_done,
    output logic        init_err,
    output logic [2:0]  err_code,
    output logic [15:0] rca,
    output logic        ccs
);

    localparam int PWR_CYCLES = POWERUP_US * CLK_FRE;
    localparam int PW = $clog2(PWR_CYCLES + 1);
    localparam int RW = $clog2(ACMD41_RETRIES + 1);
    localparam logic [PW-1:0] PWR_LAST   = PW'(PWR_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(ACMD41_RETRIES - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_PWR    = 4'd1;
    localparam logic [3:0] S_CMD0   = 4'd2;
    localparam logic [3:0] S_CMD8   = 4'd3;
    localparam logic [3:0] S_CMD55  = 4'd4;
    localparam logic [3:0] S_ACMD41 = 4'd5;
    localparam logic [3:0] S_CMD2   = 4'd6;
    localparam logic [3:0] S_CMD3   = 4'd7;
    localparam logic [3:0] S_CMD7   = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;
    localparam logic [3:0] S_ERR    = 4'd10;

    logic [3:0]    state_q, state_d;
    logic          wait_q, wait_d;
    logic          start_q, start_d;
    logic [PW-1:0] pwr_q, pwr_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          hcs_q, hcs_d;
    logic          ccs_q, ccs_d;
    logic [15:0]   rca_q, rca_d;
    logic [2:0]    code_q, code_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fast_q, fast_d;

    logic          idle_like;
    logic          fail;
    logic [2:0]    fail_code;
    logic          bad;
    logic [2:0]    bad_code;
    sd_cmd_t       cmd_s;
    logic          unused_resp;

    assign idle_like   = (state_q == S_IDLE) || (state_q == S_DONE) ||
                         (state_q == S_ERR);
    assign bad         = cmd_timeout | cmd_crc_err;
    assign bad_code    = cmd_timeout ? ERR_TIMEOUT : ERR_CRC;
    assign unused_resp = ^resp_arg[15:12];

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        start_d   = 1'b0;
        pwr_d     = pwr_q;
        retry_d   = retry_q;
        hcs_d     = hcs_q;
        ccs_d     = ccs_q;
        rca_d     = rca_q;
        code_d    = code_q;
        done_d    = done_q;
        err_d     = err_q;
        fast_d    = fast_q;
        fail      = 1'b0;
        fail_code = ERR_NONE;
        if (idle_like) begin
            if (start) begin
                state_d = S_PWR;
                wait_d  = 1'b0;
                pwr_d   = '0;
                retry_d = '0;
                hcs_d   = 1'b0;
                ccs_d   = 1'b0;
                rca_d   = '0;
                code_d  = ERR_NONE;
                done_d  = 1'b0;
                err_d   = 1'b0;
                fast_d  = 1'b0;
            end
        end else if (state_q == S_PWR) begin
            if (pwr_q == PWR_LAST) begin
                pwr_d   = '0;
                state_d = S_CMD0;
            end else begin
                pwr_d = pwr_q + 1'b1;
            end
        end else if (!wait_q) begin
            // First cycle in a command state; the pulse lands next cycle.
            start_d = 1'b1;
            wait_d  = 1'b1;
        end else if (cmd_done && !start_q) begin
            wait_d = 1'b0;
            case (state_q)
                S_CMD0: state_d = S_CMD8;
                S_CMD8: begin
                    unique case (1'b1)
                        cmd_timeout: begin
                            hcs_d   = 1'b0;
                            state_d = S_CMD55;
                        end
                        cmd_crc_err: begin
                            fail      = 1'b1;
                            fail_code = ERR_CRC;
                        end
                        (resp_arg[11:0] != CMD8_ECHO): begin
                            fail      = 1'b1;
                            fail_code = ERR_ECHO;
                        end
                        default: begin
                            hcs_d   = 1'b1;
                            state_d = S_CMD55;
                        end
                    endcase
                end
                S_CMD55: begin
                    if (bad) begin
                        fail      = 1'b1;
                        fail_code = bad_code;
                    end else begin
                        state_d = S_ACMD41;
                    end
                end
                S_ACMD41: begin
                    // R3 carries no valid CRC, so only timeout matters.
                    if (cmd_timeout) begin
                        fail      = 1'b1;
                        fail_code = ERR_TIMEOUT;
                    end else if (resp_arg[31]) begin
                        ccs_d   = resp_arg[30];
                        state_d = S_CMD2;
                    end else if (retry_q == RETRY_LAST) begin
                        retry_d   = retry_q + 1'b1;
                        fail      = 1'b1;
                        fail_code = ERR_RETRY;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_CMD55;
                    end
                end
                S_CMD2: begin
                    if (bad) begin
                        fail      = 1'b1;
                        fail_code = bad_code;
                    end else begin
                        state_d = S_CMD3;
                    end
                end
                S_CMD3: begin
                    if (bad) begin
                        fail      = 1'b1;
                        fail_code = bad_code;
                    end else begin
                        rca_d = resp_arg[31:16];
                        if (resp_arg[31:16] == 16'h0000) begin
                            fail      = 1'b1;
                            fail_code = ERR_RCA;
                        end else begin
                            state_d = S_CMD7;
                        end
                    end
                end
                S_CMD7: begin
                    if (bad) begin
                        fail      = 1'b1;
                        fail_code = bad_code;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fast_d  = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
        if (fail) begin
            state_d = S_ERR;
            code_d  = fail_code;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            start_q <= 1'b0;
            pwr_q   <= '0;
            retry_q <= '0;
            hcs_q   <= 1'b0;
            ccs_q   <= 1'b0;
            rca_q   <= '0;
            code_q  <= ERR_NONE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            start_q <= start_d;
            pwr_q   <= pwr_d;
            retry_q <= retry_d;
            hcs_q   <= hcs_d;
            ccs_q   <= ccs_d;
            rca_q   <= rca_d;
            code_q  <= code_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fast_q  <= fast_d;
        end
    end

    always_comb begin
        cmd_s = '0;
        case (state_q)
            S_CMD0:   cmd_s = mk_cmd(CMD0, 32'h0, RESP_NONE);
            S_CMD8:   cmd_s = mk_cmd(CMD8, CMD8_ARG, RESP_R1);
            S_CMD55:  cmd_s = mk_cmd(CMD55, 32'h0, RESP_R1);
            S_ACMD41: cmd_s = mk_cmd(ACMD41,
                                     hcs_q ? ACMD41_ARG_HCS : ACMD41_ARG_SD,
                                     RESP_R3);
            S_CMD2:   cmd_s = mk_cmd(CMD2, 32'h0, RESP_R2);
            S_CMD3:   cmd_s = mk_cmd(CMD3, 32'h0, RESP_R1);
            S_CMD7:   cmd_s = mk_cmd(CMD7, {rca_q, 16'h0000}, RESP_R1);
            default:  cmd_s = '0;
        endcase
    end

    assign cmd_start     = start_q;
    assign cmd_index     = cmd_s.index;
    assign cmd_arg       = cmd_s.arg;
    assign cmd_resp_type = cmd_s.rtype;
    assign busy          = ~idle_like;
    assign init_done     = done_q;
    assign init_err      = err_q;
    assign err_code      = code_q;
    assign rca           = rca_q;
    assign ccs           = ccs_q;
    assign fast_clk_sel  = fast_q;

endmodule
